if_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the RISC-V pipeline. It owns the program counter, drives a combinational instruction memory, and buffers fetched {PC, instruction} pairs in a DEPTH-entry queue. A ready/valid handshake feeds the IF/ID register. Redirects from branch or jump resolution flush the queue and reload the PC. It replaces the single-register PC plus PC+4 adder with a decoupled fetch that tolerates downstream stalls without refetching.

---
 rtl/if_fetch_queue.sv | 128 ++++++++++++
 tb/tb_if_fetch_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction-fetch front end. Owns the PC, drives a combinational
//   instruction memory and buffers fetched {pc, instr} pairs in a DEPTH-entry
//   circular queue feeding the IF/ID register over a ready/valid handshake.
//   A redirect flushes the queue and reloads the PC (word aligned).
//
//   Optional feature: define FETCH_BYPASS_EN to present the word being fetched
//   in the same cycle when the queue is empty (0-cycle fetch latency).
//
// Ports
//   clk          in   clock, rising edge
//   PCrst        in   synchronous active-high reset
//   imem_addr    out  fetch address (the internal PC)
//   imem_req     out  a fetch is performed this cycle
//   imem_rdata   in   instruction at imem_addr, same cycle
//   redirect     in   flush the queue and reload the PC
//   redirect_pc  in   new PC when redirect=1
//   out_valid    out  out_pc/out_instr hold a valid instruction
//   out_ready    in   consumer accepts the presented instruction
//   out_pc       out  PC of the presented instruction (0 when invalid)
//   out_instr    out  presented instruction (NOP when invalid)
//   misalign     out  one-cycle pulse after a redirect with redirect_pc[1:0]!=0
module if_fetch_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            PCrst,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            misalign
);

    localparam int unsigned   PTR_W = $clog2(DEPTH);
    localparam int unsigned   CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [31:0]   NOP   = 32'h0000_0013;

    logic [XLEN-1:0]  pc;
    logic [CW-1:0]    count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             misalign_q;

    logic [XLEN-1:0]  pc_store    [DEPTH];
    logic [31:0]      instr_store [DEPTH];

    logic can_fetch;
    logic q_valid;
    logic bypass;
    logic pop;
    logic fetch;
    logic push;
    logic q_pop;

    // Handshake decode. fetch depends on pop only when the queue is non-empty,
    // and bypass depends on can_fetch (not fetch), so there is no comb loop.
    always_comb begin
        can_fetch = ~redirect & ~PCrst;
        q_valid   = (count != '0);
`ifdef FETCH_BYPASS_EN
        bypass    = can_fetch & ~q_valid;
`else
        bypass    = 1'b0;
`endif
        out_valid = q_valid | bypass;
        pop       = out_valid & out_ready & ~redirect;
        fetch     = can_fetch & ((count < FULL) | pop);
        // A bypassed word that is accepted immediately never enters the queue.
        push      = fetch & ~(bypass & out_ready);
        q_pop     = pop & q_valid;
    end

    always_comb begin
        out_pc    = '0;
        out_instr = NOP;
        if (q_valid) begin
            out_pc    = pc_store[rd_ptr];
            out_instr = instr_store[rd_ptr];
        end else if (bypass) begin
            out_pc    = pc;
            out_instr = imem_rdata;
        end
    end

    assign imem_addr = pc;
    assign imem_req  = fetch;
    assign misalign  = misalign_q;

    always_ff @(posedge clk) begin
        if (PCrst) begin
            pc         <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            misalign_q <= 1'b0;
        end else if (redirect) begin
            pc         <= {redirect_pc[XLEN-1:2], 2'b00};
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            misalign_q <= |redirect_pc[1:0];
        end else begin
            misalign_q <= 1'b0;
            if (fetch) pc <= pc + XLEN'(4);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (q_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CW'(push) - CW'(q_pop);
        end
    end

    // Storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_store[wr_ptr]    <= pc;
            instr_store[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (default build, no fetch bypass).
// Uses XLEN=32, DEPTH=4, RESET_PC=0x1000; instruction memory returns
// addr ^ 0xA5A50000 so every presented instruction can be tied to its PC.
module tb_if_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_1000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            PCrst;
    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = word_at(imem_addr);

    if_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk         (clk),
        .PCrst       (PCrst),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .misalign    (misalign)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, "_pc"}, 64'(out_pc), 64'(pc));
        chk({tag, "_instr"}, 64'(out_instr), 64'(word_at(pc)));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1'b0));
        chk({tag, "_pc"}, 64'(out_pc), 64'(0));
        chk({tag, "_instr"}, 64'(out_instr), 64'(NOP));
    endtask

    initial begin
        PCrst       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        tick();
        tick();
        settle();

        // Reset state
        chk_empty("rst");
        chk("rst_addr", 64'(imem_addr), 64'(RPC));
        chk("rst_req", 64'(imem_req), 64'(1'b0));
        chk("rst_mis", 64'(misalign), 64'(1'b0));

        // Streaming with out_ready=1: first instruction presented in cycle 1
        PCrst = 1'b0;
        settle();
        chk("c0_req", 64'(imem_req), 64'(1'b1));
        chk("c0_addr", 64'(imem_addr), 64'(RPC));
        chk("c0_valid", 64'(out_valid), 64'(1'b0));
        for (int i = 0; i < 6; i++) begin
            tick();
            settle();
            chk_out("stream", RPC + 32'(4 * i));
            chk("stream_addr", 64'(imem_addr), 64'(RPC + 32'(4 * (i + 1))));
        end

        // out_ready=0 from reset: four fetches, then hold at RPC+16
        PCrst     = 1'b1;
        out_ready = 1'b0;
        tick();
        PCrst = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            chk("fill_req", 64'(imem_req), 64'(1'b1));
            chk("fill_addr", 64'(imem_addr), 64'(RPC + 32'(4 * i)));
            tick();
            settle();
        end
        chk("full_req", 64'(imem_req), 64'(1'b0));
        chk("full_addr", 64'(imem_addr), 64'(RPC + 32'd16));
        chk_out("full_head", RPC);
        tick();
        settle();
        chk("hold_req", 64'(imem_req), 64'(1'b0));
        chk("hold_addr", 64'(imem_addr), 64'(RPC + 32'd16));
        chk_out("hold_head", RPC);

        // Drain at full: fetch resumes in the cycle of the first pop, then
        // fetch+pop every cycle across several pointer wraps
        out_ready = 1'b1;
        settle();
        chk("drain_req0", 64'(imem_req), 64'(1'b1));
        chk("drain_addr0", 64'(imem_addr), 64'(RPC + 32'd16));
        chk_out("drain0", RPC);
        for (int i = 1; i < 15; i++) begin
            tick();
            settle();
            chk_out("drain", RPC + 32'(4 * i));
            chk("drain_req", 64'(imem_req), 64'(1'b1));
            chk("drain_addr", 64'(imem_addr), 64'(RPC + 32'd16 + 32'(4 * i)));
        end

        // Redirect while count=3 and out_ready=1
        PCrst     = 1'b1;
        out_ready = 1'b0;
        tick();
        PCrst = 1'b0;
        tick();
        tick();
        tick();
        settle();
        chk_out("pre_redir", RPC);
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        settle();
        chk("redir_req", 64'(imem_req), 64'(1'b0));
        tick();
        redirect = 1'b0;
        settle();
        chk_empty("redir_bubble");
        chk("redir_addr", 64'(imem_addr), 64'(32'h2000));
        chk("redir_req1", 64'(imem_req), 64'(1'b1));
        chk("redir_mis", 64'(misalign), 64'(1'b0));
        tick();
        settle();
        chk_out("redir_first", 32'h2000);
        chk("redir_addr2", 64'(imem_addr), 64'(32'h2004));
        tick();
        settle();
        chk_out("redir_second", 32'h2004);

        // Misaligned redirect: PC aligned down, one-cycle misalign pulse
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2006;
        tick();
        redirect = 1'b0;
        settle();
        chk("mis_pulse", 64'(misalign), 64'(1'b1));
        chk("mis_addr", 64'(imem_addr), 64'(32'h2004));
        chk_empty("mis_bubble");
        tick();
        settle();
        chk("mis_clear", 64'(misalign), 64'(1'b0));
        chk_out("mis_first", 32'h2004);

        // Back-to-back redirects: the last one wins
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        tick();
        redirect_pc = 32'h0000_3102;
        tick();
        redirect = 1'b0;
        settle();
        chk("b2b_addr", 64'(imem_addr), 64'(32'h3100));
        chk("b2b_mis", 64'(misalign), 64'(1'b1));
        chk_empty("b2b_bubble");
        tick();
        settle();
        chk_out("b2b_first", 32'h3100);
        chk("b2b_mis_clr", 64'(misalign), 64'(1'b0));

        // Reset with two queued entries (and a concurrent redirect)
        out_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_5000;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        settle();
        chk_out("prerst_head", 32'h5000);
        PCrst       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_6000;
        tick();
        PCrst    = 1'b0;
        redirect = 1'b0;
        settle();
        chk_empty("midrst");
        chk("midrst_addr", 64'(imem_addr), 64'(RPC));
        chk("midrst_req", 64'(imem_req), 64'(1'b1));
        tick();
        settle();
        chk_out("midrst_head", RPC);

        // PC wrap at 2^32
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        settle();
        chk("wrap_addr0", 64'(imem_addr), 64'(32'hFFFF_FFF8));
        tick();
        settle();
        chk_out("wrap0", 32'hFFFF_FFF8);
        chk("wrap_addr1", 64'(imem_addr), 64'(32'hFFFF_FFFC));
        tick();
        settle();
        chk_out("wrap1", 32'hFFFF_FFFC);
        chk("wrap_addr2", 64'(imem_addr), 64'(32'h0000_0000));
        tick();
        settle();
        chk_out("wrap2", 32'h0000_0000);
        chk("wrap_addr3", 64'(imem_addr), 64'(32'h0000_0004));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
